// File: rtl/mul_inject_arbiter.sv
// mul_inject_arbiter
//   Sits between instruction fetch and decode. When a multiply (MULI, MULR,
//   MULSI, MULSR) shows up in the fetched stream it is removed from the
//   stream. The arbiter then launches the multiply microcode sequencer with
//   the latched operand fields and stalls fetch. It forwards the sequencer's
//   instructions to ID until the sequencer releases. On release it strobes
//   the saved flags back to execute. A watchdog aborts a sequencer that
//   never releases.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   fetch_instr/valid      instruction stream from fetch
//   stall_fetch            fetch holds PC and instruction
//   id_instr               instruction presented to ID
//   flags_in               current NZCV (the sequencer saves these itself)
//   start_mul              one-cycle sequencer launch pulse
//   mul_dest/src/imm/type  latched operand fields of the MUL
//   rf_raddr, rf_rdata     register-file read of the multiplier operand
//   read_data_second       multiplier value handed to the sequencer
//   ucode_instr/mux_ctrl   sequencer instruction and its valid
//   mul_release            sequencer done pulse
//   ucode_flags            saved flags returned by the sequencer
//   flags_restore(_valid)  flags write-back and its one-cycle strobe
//   timeout_err            sticky watchdog abort
//   inject_count           instructions injected for the current MUL
module mul_inject_arbiter #(
  parameter logic [6:0] MULI_OP  = 7'b0010011,
  parameter logic [6:0] MULR_OP  = 7'b0110011,
  parameter logic [6:0] MULSI_OP = 7'b0011011,
  parameter logic [6:0] MULSR_OP = 7'b0111011,
  parameter int unsigned TIMEOUT = 70000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_instr,
  input  logic        fetch_valid,
  output logic        stall_fetch,
  output logic [31:0] id_instr,
  input  logic [3:0]  flags_in,
  output logic        start_mul,
  output logic [3:0]  mul_dest,
  output logic [3:0]  mul_src,
  output logic [15:0] mul_imm,
  output logic [1:0]  mul_type,
  output logic [3:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [31:0] read_data_second,
  input  logic [31:0] ucode_instr,
  input  logic        ucode_mux_ctrl,
  input  logic        mul_release,
  input  logic [3:0]  ucode_flags,
  output logic [3:0]  flags_restore,
  output logic        flags_restore_valid,
  output logic        timeout_err,
  output logic [15:0] inject_count
);

  localparam logic [31:0] NOP = {5'b11001, 27'b0};
  localparam logic [16:0] WD_LAST = 17'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t      state;
  logic [16:0] wd_cnt;
  logic        is_mul;
  logic [1:0]  det_type;

  // The sequencer snapshots NZCV on its own; flags_in is not needed here.
  logic unused_flags;
  assign unused_flags = ^flags_in;

  always_comb begin
    is_mul   = 1'b0;
    det_type = 2'd0;
    if (fetch_valid) begin
      unique case (fetch_instr[31:25])
        MULI_OP:  begin is_mul = 1'b1; det_type = 2'd0; end
        MULR_OP:  begin is_mul = 1'b1; det_type = 2'd1; end
        MULSI_OP: begin is_mul = 1'b1; det_type = 2'd2; end
        MULSR_OP: begin is_mul = 1'b1; det_type = 2'd3; end
        default:  begin is_mul = 1'b0; det_type = 2'd0; end
      endcase
    end
  end

  // ID mux, stall and launch are decoded from the state register.
  // The register variants (MULR/MULSR) have mul_type[0] set.
  always_comb begin
    id_instr         = NOP;
    stall_fetch      = 1'b0;
    start_mul        = 1'b0;
    read_data_second = 32'd0;
    case (state)
      IDLE: begin
        if (fetch_valid && !is_mul) id_instr = fetch_instr;
      end
      LAUNCH: begin
        start_mul   = 1'b1;
        stall_fetch = 1'b1;
        if (mul_type[0]) read_data_second = rf_rdata;
      end
      WAIT: begin
        stall_fetch = 1'b1;
        if (ucode_mux_ctrl) id_instr = ucode_instr;
      end
      default: begin
        id_instr = NOP;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      wd_cnt              <= 17'd0;
      mul_dest            <= 4'd0;
      mul_src             <= 4'd0;
      mul_imm             <= 16'd0;
      mul_type            <= 2'd0;
      rf_raddr            <= 4'd0;
      flags_restore       <= 4'd0;
      flags_restore_valid <= 1'b0;
      timeout_err         <= 1'b0;
      inject_count        <= 16'd0;
    end else begin
      flags_restore_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (is_mul) begin
            mul_dest <= fetch_instr[24:21];
            mul_src  <= fetch_instr[20:17];
            mul_imm  <= fetch_instr[15:0];
            mul_type <= det_type;
            rf_raddr <= fetch_instr[16:13];
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd_cnt       <= 17'd0;
          inject_count <= 16'd0;
          state        <= WAIT;
        end
        WAIT: begin
          // An instruction presented alongside the release is still counted.
          if (ucode_mux_ctrl && inject_count != 16'hFFFF)
            inject_count <= inject_count + 16'd1;
          if (mul_release) begin
            flags_restore       <= ucode_flags;
            flags_restore_valid <= 1'b1;
            state               <= IDLE;
          end else if (wd_cnt == WD_LAST) begin
            // TIMEOUT cycles spent in WAIT: abort without restoring flags.
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 17'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
